// File: rtl/arm_emit_buffer_if.sv
// Bundle between the JVM state machine, the code RAM and the ARM emit buffer.
// The slave modport is the buffer's view; the master modport is the surrounding logic.
interface arm_emit_buffer_if #(
  parameter int AW         = 3,
  parameter int CODE_ADR_W = 12
);
  // Handshakes: a template is accepted on a clock edge when in_valid is high
  // and waiting is low; a code RAM write completes on an edge where code_we
  // and code_ready are both high. Neither side may make its valid depend on
  // the other side's ready within the same cycle.
  logic                  in_valid;
  logic [31:0]           in_word;
  logic [1:0]            in_patch;
  logic                  param_valid;
  logic [7:0]            param_byte;
  logic                  flush;
  logic                  code_ready;
  logic                  waiting;
  logic                  code_we;
  logic [CODE_ADR_W-1:0] code_adr;
  logic [31:0]           code_data;
  logic [AW:0]           count;
  logic                  flush_done;
  logic                  err;
  logic [1:0]            dbg_state;

  modport slave (
    input  in_valid, in_word, in_patch, param_valid, param_byte, flush, code_ready,
    output waiting, code_we, code_adr, code_data, count, flush_done, err, dbg_state
  );

  modport master (
    output in_valid, in_word, in_patch, param_valid, param_byte, flush, code_ready,
    input  waiting, code_we, code_adr, code_data, count, flush_done, err, dbg_state
  );
endinterface

// File: rtl/arm_emit_buffer.sv
// Patches ARM instruction templates with JVM operand bytes, queues them in a
// FIFO and drains the FIFO into consecutive code RAM addresses.
module arm_emit_buffer #(
  parameter int DEPTH      = 8,
  parameter int AW         = 3,
  parameter int CODE_ADR_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  arm_emit_buffer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [CODE_ADR_W-1:0] code_adr_q, code_adr_d;
  logic [15:0]           par_q, par_d;
  logic [1:0]            pcnt_q, pcnt_d;
  logic                  err_q, err_d;
  logic [31:0]           mem_q [DEPTH];

  logic                  waiting;
  logic                  push;
  logic                  pop;
  logic                  underflow;
  logic [31:0]           patched_word;

  // Stall is decoded from registered state only, so upstream sees no loop.
  assign waiting = (state_q != ST_RUN) || (count_q == FULL_CNT);
  assign push    = bus.in_valid && !waiting;
  assign pop     = (count_q != '0) && bus.code_ready;

  always_comb begin
    patched_word = bus.in_word;
    underflow    = 1'b0;
    case (bus.in_patch)
      2'b01: begin
        patched_word[7:0] = par_q[7:0];
        underflow         = (pcnt_q == 2'd0);
      end
      2'b10: begin
        patched_word[11:0] = par_q[11:0];
        underflow          = (pcnt_q != 2'd2);
      end
      2'b11: begin
        patched_word[23:0] = {{8{par_q[15]}}, par_q};
        underflow          = (pcnt_q != 2'd2);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    code_adr_d = code_adr_q;
    par_d      = par_q;
    pcnt_d     = pcnt_q;
    err_d      = err_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      code_adr_d = code_adr_q + CODE_ADR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: ;
    endcase

    // A patching push consumes the operand; a byte in the same cycle starts the next one.
    if (push && (bus.in_patch != 2'b00)) begin
      if (bus.param_valid) begin
        par_d  = {8'h00, bus.param_byte};
        pcnt_d = 2'd1;
      end else begin
        par_d  = 16'h0000;
        pcnt_d = 2'd0;
      end
    end else if (bus.param_valid) begin
      par_d = {par_q[7:0], bus.param_byte};
      if (pcnt_q != 2'd2) pcnt_d = pcnt_q + 2'd1;
    end

    if (push && underflow) err_d = 1'b1;

    case (state_q)
      ST_RUN:   if (bus.flush) state_d = ST_FLUSH;
      ST_FLUSH: if (count_q == '0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      code_adr_q <= '0;
      par_q      <= '0;
      pcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      code_adr_q <= code_adr_d;
      par_q      <= par_d;
      pcnt_q     <= pcnt_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: count and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= patched_word;
  end

  assign bus.waiting    = waiting;
  assign bus.code_we    = (count_q != '0);
  assign bus.code_adr   = code_adr_q;
  assign bus.code_data  = mem_q[rd_ptr_q];
  assign bus.count      = count_q;
  assign bus.flush_done = (state_q == ST_DONE);
  assign bus.err        = err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_arm_emit_buffer.sv
// Directed bench for arm_emit_buffer: drivers push hand-computed words into a
// queue, a negedge monitor checks every code RAM write against it.
module tb_arm_emit_buffer;

  localparam int DEPTH      = 8;
  localparam int AW         = 3;
  localparam int CODE_ADR_W = 12;

  logic clk;
  logic rst_n;

  arm_emit_buffer_if #(.AW(AW), .CODE_ADR_W(CODE_ADR_W)) bus ();

  arm_emit_buffer #(.DEPTH(DEPTH), .AW(AW), .CODE_ADR_W(CODE_ADR_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0]           exp_q[$];
  logic [CODE_ADR_W-1:0] exp_adr;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%h req=%h at %0t", name, act, req, $time);
    end
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    exp_adr = '0;
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_code_we", 32'(bus.code_we), 32'd0);
    check("rst_code_adr", 32'(bus.code_adr), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_waiting", 32'(bus.waiting), 32'd0);
    check("rst_flush_done", 32'(bus.flush_done), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_param(input logic [7:0] b);
    bus.param_valid = 1'b1;
    bus.param_byte  = b;
    @(posedge clk);
    #1;
    bus.param_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input logic [1:0] p, input logic [31:0] expw,
                           input logic pv, input logic [7:0] pb, output logic accepted);
    bus.in_valid    = 1'b1;
    bus.in_word     = w;
    bus.in_patch    = p;
    bus.param_valid = pv;
    bus.param_byte  = pb;
    accepted        = !bus.waiting;
    @(posedge clk);
    if (accepted) exp_q.push_back(expw);
    #1;
    bus.in_valid    = 1'b0;
    bus.param_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (bus.count != '0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_count", 32'(bus.count), 32'd0);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("mon_count", 32'(bus.count), 32'(exp_q.size()));
      check("mon_code_we", 32'(bus.code_we), 32'(exp_q.size() != 0));
      if (bus.code_we && bus.code_ready && exp_q.size() != 0) begin
        check("mon_code_data", bus.code_data, exp_q.pop_front());
        check("mon_code_adr", 32'(bus.code_adr), 32'(exp_adr));
        exp_adr = exp_adr + CODE_ADR_W'(1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    logic cr_seq [6];
    logic fd_seq [6];
    logic wt_seq [6];
    cr_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    fd_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wt_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    rst_n           = 1'b0;
    exp_adr         = '0;
    bus.in_valid    = 1'b0;
    bus.in_word     = '0;
    bus.in_patch    = 2'b00;
    bus.param_valid = 1'b0;
    bus.param_byte  = '0;
    bus.flush       = 1'b0;
    bus.code_ready  = 1'b0;
    do_reset();

    // Single unpatched word: written at address 0, then address advances.
    bus.code_ready = 1'b1;
    push_word(32'hE3A00000, 2'b00, 32'hE3A00000, 1'b0, 8'h00, acc);
    check("t1_code_we", 32'(bus.code_we), 32'd1);
    check("t1_code_data", bus.code_data, 32'hE3A00000);
    check("t1_code_adr0", 32'(bus.code_adr), 32'd0);
    idle(1);
    check("t1_code_adr1", 32'(bus.code_adr), 32'd1);
    check("t1_count", 32'(bus.count), 32'd0);

    // imm12 patch, then an imm8 patch with no operand -> sticky err.
    send_param(8'h12);
    send_param(8'h34);
    push_word(32'hE3A00000, 2'b10, 32'hE3A00234, 1'b0, 8'h00, acc);
    check("t2_err_clear", 32'(bus.err), 32'd0);
    push_word(32'hE3A010FF, 2'b01, 32'hE3A01000, 1'b0, 8'h00, acc);
    check("t2_err_set", 32'(bus.err), 32'd1);
    idle(3);
    check("t2_err_sticky", 32'(bus.err), 32'd1);

    // off24 sign extension, and an operand byte arriving with the push.
    do_reset();
    bus.code_ready = 1'b1;
    send_param(8'hFF);
    send_param(8'hFE);
    push_word(32'hEA000000, 2'b11, 32'hEAFFFFFE, 1'b0, 8'h00, acc);
    send_param(8'hFF);
    send_param(8'hFE);
    push_word(32'hEA000000, 2'b11, 32'hEAFFFFFE, 1'b1, 8'h07, acc);
    push_word(32'hE3A00000, 2'b01, 32'hE3A00007, 1'b0, 8'h00, acc);
    check("t3_err", 32'(bus.err), 32'd0);
    drain(10);

    // Fill to full with the RAM stalled, drop a ninth word, then drain in order.
    do_reset();
    bus.code_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      push_word(32'h1000_0000 + 32'(i), 2'b00, 32'h1000_0000 + 32'(i), 1'b0, 8'h00, acc);
      check("t4_accept", 32'(acc), 32'd1);
    end
    check("t4_full_count", 32'(bus.count), 32'd8);
    check("t4_full_waiting", 32'(bus.waiting), 32'd1);
    push_word(32'hDEADBEEF, 2'b00, 32'hDEADBEEF, 1'b0, 8'h00, acc);
    check("t4_drop_9th", 32'(bus.count), 32'd8);
    bus.code_ready = 1'b1;
    idle(1);
    check("t4_waiting_release", 32'(bus.waiting), 32'd0);
    drain(20);
    check("t4_final_adr", 32'(bus.code_adr), 32'd8);

    // Flush with three queued words while the RAM ready toggles.
    do_reset();
    bus.code_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_word(32'h2000_0000 + 32'(i), 2'b00, 32'h2000_0000 + 32'(i), 1'b0, 8'h00, acc);
    for (int i = 0; i < 6; i++) begin
      bus.code_ready = cr_seq[i];
      bus.flush      = (i == 0);
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("t5_waiting", 32'(bus.waiting), 32'(wt_seq[i]));
      check("t5_flush_done", 32'(bus.flush_done), 32'(fd_seq[i]));
    end
    check("t5_count", 32'(bus.count), 32'd0);

    // Code address wrap after 4096 writes.
    do_reset();
    bus.code_ready = 1'b1;
    for (int i = 0; i < 4096; i++)
      push_word(32'(i), 2'b00, 32'(i), 1'b0, 8'h00, acc);
    drain(10);
    check("t6_adr_wrap", 32'(bus.code_adr), 32'd0);
    push_word(32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, 1'b0, 8'h00, acc);
    drain(10);

    // Asynchronous reset with four words queued.
    bus.code_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_word(32'h3000_0000 + 32'(i), 2'b00, 32'h3000_0000 + 32'(i), 1'b0, 8'h00, acc);
    check("t7_pre_count", 32'(bus.count), 32'd4);
    do_reset();
    idle(2);
    check("t7_post_count", 32'(bus.count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
